// File: rtl/rsa_pkg.sv
// rsa_pkg
//   Shared constants and types for the RSA arithmetic units.
//   W       : modulus / residue width
//   DW      : dividend width (2*W)
//   CNT_W   : iteration counter width, $clog2(2*W)
//   modred_state_t : reduction FSM states (IDLE, RUN, DONE)
package rsa_pkg;

    localparam int W     = 64;
    localparam int DW    = 2 * W;
    localparam int CNT_W = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } modred_state_t;

endpackage : rsa_pkg

// File: rtl/modred_64_if.sv
// modred_64_if
//   Request/response bundle of the modular-reduction stage.
//   start    : single-cycle request (master -> slave)
//   dividend : 2W-bit value to reduce (master -> slave)
//   modulus  : W-bit modulus N (master -> slave)
//   result   : W-bit residue, valid while ready_n=0 (slave -> master)
//   ready_n  : active-low result-valid (slave -> master)
//   busy     : high while iterating (slave -> master)
//   err      : zero-modulus flag, valid with ready_n=0 (slave -> master)
//   quotient : 2W-bit quotient, only when MODRED_QUOT_EN is defined
interface modred_64_if;
    import rsa_pkg::*;

    logic          start;
    logic [DW-1:0] dividend;
    logic [W-1:0]  modulus;
    logic [W-1:0]  result;
    logic          ready_n;
    logic          busy;
    logic          err;
`ifdef MODRED_QUOT_EN
    logic [DW-1:0] quotient;

    modport master (output start, dividend, modulus,
                    input  result, ready_n, busy, err, quotient);
    modport slave  (input  start, dividend, modulus,
                    output result, ready_n, busy, err, quotient);
`else
    modport master (output start, dividend, modulus,
                    input  result, ready_n, busy, err);
    modport slave  (input  start, dividend, modulus,
                    output result, ready_n, busy, err);
`endif

endinterface : modred_64_if

// File: rtl/modred_step.sv
// modred_step
//   One restoring-division step, purely combinational.
//   t        : (W+1)-bit partial remainder after shifting in the next dividend bit
//   n        : W-bit modulus
//   rem_next : t - n when t >= n, otherwise t (always < n, so W bits suffice)
//   q_bit    : 1 when the subtraction was taken
module modred_step
    import rsa_pkg::*;
(
    input  logic [W:0]   t,
    input  logic [W-1:0] n,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W-1:0] diff_s;

    // The compare must see t[W]; the subtraction result is known to fit in
    // W bits whenever it is selected, so a W-bit wrap-around subtract is exact.
    assign diff_s = t[W-1:0] - n;

    // Select subtracted or restored remainder.
    always_comb begin
        rem_next = t[W-1:0];
        q_bit    = 1'b0;
        if (t >= {1'b0, n}) begin
            rem_next = diff_s;
            q_bit    = 1'b1;
        end else begin
            rem_next = t[W-1:0];
            q_bit    = 1'b0;
        end
    end

endmodule : modred_step

// File: rtl/modred_64.sv
// modred_64
//   Multi-cycle modular reduction R = D mod N (D is 2W bits, N is W bits),
//   restoring shift/compare/subtract, one dividend bit per clock.
//   Latency is 2W clocks from the accepting edge; a zero modulus completes
//   on the accepting edge itself with err=1.
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset, highest priority
//     bus : modred_64_if.slave (start, dividend, modulus, result, ready_n,
//           busy, err, and quotient when enabled)
//   Optional feature: define MODRED_QUOT_EN to add the 2W-bit quotient output.
module modred_64
    import rsa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    modred_64_if.slave  bus
);

    modred_state_t  state_r, state_nxt_s;
    logic [W-1:0]   rem_r, rem_nxt_s;
    logic [DW-1:0]  shreg_r, shreg_nxt_s;
    logic [W-1:0]   n_r, n_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [W-1:0]   result_r, result_nxt_s;
    logic           ready_n_r, ready_n_nxt_s;
    logic           busy_r, busy_nxt_s;
    logic           err_r, err_nxt_s;
`ifdef MODRED_QUOT_EN
    logic [DW-1:0]  quot_r, quot_nxt_s;
`endif

    logic [W:0]     t_s;
    logic [W-1:0]   step_rem_s;
    logic           q_bit_s;

    // Partial remainder with the next dividend bit appended, kept at W+1 bits.
    assign t_s = {rem_r, shreg_r[DW-1]};

    modred_step u_step (
        .t        (t_s),
        .n        (n_r),
        .rem_next (step_rem_s),
        .q_bit    (q_bit_s)
    );

`ifndef MODRED_QUOT_EN
    logic unused_q_bit_s;
    assign unused_q_bit_s = q_bit_s;
`endif

    // Next-state and next-output logic for the reduction FSM.
    always_comb begin
        state_nxt_s   = state_r;
        rem_nxt_s     = rem_r;
        shreg_nxt_s   = shreg_r;
        n_nxt_s       = n_r;
        cnt_nxt_s     = cnt_r;
        result_nxt_s  = result_r;
        ready_n_nxt_s = ready_n_r;
        busy_nxt_s    = busy_r;
        err_nxt_s     = err_r;
`ifdef MODRED_QUOT_EN
        quot_nxt_s    = quot_r;
`endif
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    shreg_nxt_s = bus.dividend;
                    n_nxt_s     = bus.modulus;
                    rem_nxt_s   = {W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b1}};
                    result_nxt_s = {W{1'b0}};
`ifdef MODRED_QUOT_EN
                    quot_nxt_s  = {DW{1'b0}};
`endif
                    if (bus.modulus == {W{1'b0}}) begin
                        state_nxt_s   = DONE;
                        err_nxt_s     = 1'b1;
                        ready_n_nxt_s = 1'b0;
                        busy_nxt_s    = 1'b0;
                    end else begin
                        state_nxt_s   = RUN;
                        err_nxt_s     = 1'b0;
                        ready_n_nxt_s = 1'b1;
                        busy_nxt_s    = 1'b1;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RUN: begin
                // start is deliberately not looked at here.
                rem_nxt_s   = step_rem_s;
                shreg_nxt_s = {shreg_r[DW-2:0], 1'b0};
                cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef MODRED_QUOT_EN
                quot_nxt_s  = {quot_r[DW-2:0], q_bit_s};
`endif
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s   = DONE;
                    result_nxt_s  = step_rem_s;
                    ready_n_nxt_s = 1'b0;
                    busy_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                result_nxt_s  = {W{1'b0}};
                ready_n_nxt_s = 1'b1;
                busy_nxt_s    = 1'b0;
                err_nxt_s     = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            rem_r     <= {W{1'b0}};
            shreg_r   <= {DW{1'b0}};
            n_r       <= {W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            result_r  <= {W{1'b0}};
            ready_n_r <= 1'b1;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
`ifdef MODRED_QUOT_EN
            quot_r    <= {DW{1'b0}};
`endif
        end else begin
            state_r   <= state_nxt_s;
            rem_r     <= rem_nxt_s;
            shreg_r   <= shreg_nxt_s;
            n_r       <= n_nxt_s;
            cnt_r     <= cnt_nxt_s;
            result_r  <= result_nxt_s;
            ready_n_r <= ready_n_nxt_s;
            busy_r    <= busy_nxt_s;
            err_r     <= err_nxt_s;
`ifdef MODRED_QUOT_EN
            quot_r    <= quot_nxt_s;
`endif
        end
    end

    assign bus.result  = result_r;
    assign bus.ready_n = ready_n_r;
    assign bus.busy    = busy_r;
    assign bus.err     = err_r;
`ifdef MODRED_QUOT_EN
    assign bus.quotient = quot_r;
`endif

endmodule : modred_64
